// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stage indices,
// request priority encoding and default counter width.
package pipe_ctrl_pkg;

    localparam int unsigned STG_FETCH = 0;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ReqNone,
        ReqStall,
        ReqFlush
    } req_e;

    // Flush outranks stall; a stall seen together with a flush is dropped.
    function automatic req_e req_decode(input logic s, input logic f);
        if (f) begin
            return ReqFlush;
        end else if (s) begin
            return ReqStall;
        end
        return ReqNone;
    endfunction

endpackage

// File: rtl/pipe_done_acc.sv
// Per-stage completion accumulator; all_done is high once every stage that
// was started has reported done (either earlier or in this cycle).
module pipe_done_acc #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] stage_done,
    input  logic             advance,
    input  logic [WIDTH-1:0] next_valid,
    output logic             all_done
);

    logic [WIDTH-1:0] done_acc_q;

    // Stages without a live op count as done from the start.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_acc_q <= '1;
        end else if (advance) begin
            done_acc_q <= ~next_valid;
        end else begin
            done_acc_q <= done_acc_q | stage_done;
        end
    end

    assign all_done = &(done_acc_q | stage_done);

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage lock-step pipeline controller: advances when every live stage is
// done, with latched stall/flush requests, halt-drain and a stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned STALL_AT = NSTAGE - 1,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stage_done,
    input  logic              stall_req,
    input  logic              flush,
    input  logic              halt,
    output logic [NSTAGE-1:0] stage_enable,
    output logic [NSTAGE-1:0] stage_valid,
    output logic              advance,
    output logic              idle,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [NSTAGE-1:0] valid_q;
    logic [NSTAGE-1:0] next_valid;
    logic [NSTAGE-1:0] shifted;
    logic              stall_pend_q;
    logic              flush_pend_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              all_done;
    req_e              req;

    pipe_done_acc #(
        .WIDTH (NSTAGE)
    ) u_done_acc (
        .clk        (clk),
        .rst        (rst),
        .stage_done (stage_done),
        .advance    (advance),
        .next_valid (next_valid),
        .all_done   (all_done)
    );

    assign advance = all_done & ~rst;
    assign req     = req_decode(stall_req | stall_pend_q, flush | flush_pend_q);
    assign shifted = {valid_q[NSTAGE-2:0], ~halt};

    always_comb begin
        next_valid = '0;
        unique case (req)
            ReqFlush: next_valid[STG_FETCH] = ~halt;
            // Stages below the bubble re-issue in place; older stages move on.
            ReqStall: begin
                for (int unsigned i = 0; i < NSTAGE; i++) begin
                    if (i < STALL_AT) begin
                        next_valid[i] = valid_q[i];
                    end else if (i > STALL_AT) begin
                        next_valid[i] = shifted[i];
                    end
                end
            end
            default: next_valid = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            stall_pend_q <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else if (advance) begin
            valid_q      <= next_valid;
            stall_pend_q <= 1'b0;
            flush_pend_q <= 1'b0;
            if (req == ReqStall && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            stall_pend_q <= stall_pend_q | stall_req;
            flush_pend_q <= flush_pend_q | flush;
        end
    end

    assign stage_enable = advance ? next_valid : '0;
    assign stage_valid  = rst ? '0 : valid_q;
    assign stall_cnt    = rst ? '0 : cnt_q;
    assign idle         = ~|valid_q & all_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations, then
// random traffic compared every cycle against an op-occupancy model.
module tb_pipe_ctrl;

    localparam int NS = 4;
    localparam int SA = 2;
    localparam int CW = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] stage_done = '0;
    logic          stall_req = 1'b0;
    logic          flush = 1'b0;
    logic          halt = 1'b0;
    logic [NS-1:0] stage_enable;
    logic [NS-1:0] stage_valid;
    logic          advance;
    logic          idle;
    logic [CW-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model: which op id sits in each stage (-1 = empty), which stages still
    // owe a completion, pending requests and the stall count.
    int m_occ [NS];
    int m_nxt [NS];
    bit m_busy [NS];
    bit m_spend, m_fpend;
    int m_cnt;
    int m_id;

    pipe_ctrl #(
        .NSTAGE   (NS),
        .STALL_AT (SA),
        .CNT_W    (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stage_done   (stage_done),
        .stall_req    (stall_req),
        .flush        (flush),
        .halt         (halt),
        .stage_enable (stage_enable),
        .stage_valid  (stage_valid),
        .advance      (advance),
        .idle         (idle),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit m_all_done();
        for (int i = 0; i < NS; i++) begin
            if (m_busy[i] && !stage_done[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void m_calc_next(input bit s, input bit f);
        if (f) begin
            for (int i = 0; i < NS; i++) m_nxt[i] = -1;
            m_nxt[0] = halt ? -1 : m_id;
        end else if (s) begin
            for (int i = 0; i < NS; i++) begin
                if (i < SA) m_nxt[i] = m_occ[i];
                else if (i == SA) m_nxt[i] = -1;
                else m_nxt[i] = m_occ[i-1];
            end
        end else begin
            m_nxt[0] = halt ? -1 : m_id;
            for (int i = 1; i < NS; i++) m_nxt[i] = m_occ[i-1];
        end
    endfunction

    function automatic logic [NS-1:0] occ_bits(input bit use_next);
        logic [NS-1:0] b;
        for (int i = 0; i < NS; i++) b[i] = use_next ? (m_nxt[i] >= 0) : (m_occ[i] >= 0);
        return b;
    endfunction

    task automatic model_step();
        bit s, f, ad;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_occ[i]  = -1;
                m_busy[i] = 1'b0;
            end
            m_spend = 1'b0;
            m_fpend = 1'b0;
            m_cnt   = 0;
            return;
        end
        s  = stall_req || m_spend;
        f  = flush || m_fpend;
        ad = m_all_done();
        if (ad) begin
            m_calc_next(s, f);
            if (m_nxt[0] == m_id) m_id++;
            for (int i = 0; i < NS; i++) begin
                m_occ[i]  = m_nxt[i];
                m_busy[i] = (m_nxt[i] >= 0);
            end
            m_spend = 1'b0;
            m_fpend = 1'b0;
            if (s && !f && m_cnt < CNT_MAX) m_cnt++;
        end else begin
            for (int i = 0; i < NS; i++) if (stage_done[i]) m_busy[i] = 1'b0;
            m_spend = m_spend || stall_req;
            m_fpend = m_fpend || flush;
        end
    endtask

    task automatic compare();
        bit ad;
        logic [NS-1:0] en;
        if (rst) begin
            check("advance_rst", 32'(advance), 32'(0));
            check("enable_rst", 32'(stage_enable), 32'(0));
            check("valid_rst", 32'(stage_valid), 32'(0));
            check("cnt_rst", 32'(stall_cnt), 32'(0));
            return;
        end
        ad = m_all_done();
        m_calc_next(stall_req || m_spend, flush || m_fpend);
        en = ad ? occ_bits(1'b1) : '0;
        check("advance", 32'(advance), 32'(ad));
        check("stage_enable", 32'(stage_enable), 32'(en));
        check("stage_valid", 32'(stage_valid), 32'(occ_bits(1'b0)));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        check("idle", 32'(idle), 32'((occ_bits(1'b0) == '0) && ad));
    endtask

    initial begin
        m_id = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) compare();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        // Fill with every stage finishing straight away.
        rst = 1'b1;
        stage_done = '1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        at_neg(); check("fill0", 32'(stage_enable), 32'h1); tick();
        at_neg(); check("fill1", 32'(stage_enable), 32'h3); tick();
        at_neg(); check("fill2", 32'(stage_enable), 32'h7); tick();
        at_neg(); check("fill3", 32'(stage_enable), 32'hf);
        check("fill3_adv", 32'(advance), 32'h1); tick();
        at_neg(); check("fill4", 32'(stage_enable), 32'hf); tick();

        // Stall on a full pipe: bubble at stage 2.
        stall_req = 1'b1;
        at_neg(); check("stall_en", 32'(stage_enable), 32'hb); tick();
        stall_req = 1'b0;
        at_neg(); check("stall_valid", 32'(stage_valid), 32'hb);
        check("stall_cnt1", 32'(stall_cnt), 32'h1);
        check("post_stall_en", 32'(stage_enable), 32'h7); tick();

        // Stage 2 late by three cycles; earlier done pulses stay latched.
        stage_done = 4'b0011;
        at_neg(); check("late_adv0", 32'(advance), 32'h0);
        check("late_en0", 32'(stage_enable), 32'h0); tick();
        stage_done = 4'b0000;
        at_neg(); check("late_adv1", 32'(advance), 32'h0); tick();
        at_neg(); check("late_en2", 32'(stage_enable), 32'h0); tick();
        stage_done = 4'b0100;
        at_neg(); check("late_release", 32'(stage_enable), 32'hf); tick();

        // Flush and stall together while stage 1 is busy.
        stage_done = 4'b1101;
        stall_req = 1'b1;
        flush = 1'b1;
        at_neg(); check("fs_wait", 32'(advance), 32'h0); tick();
        stall_req = 1'b0;
        flush = 1'b0;
        stage_done = 4'b0010;
        at_neg(); check("fs_en", 32'(stage_enable), 32'h1); tick();
        stage_done = '1;
        at_neg(); check("fs_cnt", 32'(stall_cnt), 32'h1);
        check("fs_cleared", 32'(stage_enable), 32'h3); tick();

        // Halt drain from a full pipe.
        tick(); tick();
        halt = 1'b1;
        tick();
        at_neg(); check("drain0", 32'(stage_valid), 32'he); tick();
        at_neg(); check("drain1", 32'(stage_valid), 32'hc); tick();
        at_neg(); check("drain2", 32'(stage_valid), 32'h8); tick();
        at_neg(); check("drain3", 32'(stage_valid), 32'h0);
        check("drain_idle", 32'(idle), 32'h1);
        check("drain_en", 32'(stage_enable), 32'h0); tick();

        // Reset in the middle of a drain restarts from fetch.
        halt = 1'b0;
        repeat (4) tick();
        halt = 1'b1;
        tick(); tick();
        rst = 1'b1;
        at_neg(); check("rst_en", 32'(stage_enable), 32'h0);
        check("rst_valid", 32'(stage_valid), 32'h0); tick();
        rst = 1'b0;
        halt = 1'b0;
        at_neg(); check("rst_restart", 32'(stage_enable), 32'h1); tick();

        // Counter saturation at 2 bits.
        stall_req = 1'b1;
        repeat (5) tick();
        at_neg(); check("sat5", 32'(stall_cnt), 32'h3); tick();
        at_neg(); check("sat6", 32'(stall_cnt), 32'h3); tick();
        stall_req = 1'b0;

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NS; i++) stage_done[i] = ($urandom_range(0, 9) < 6);
            stall_req = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline sequencing controller, the N-stage successor to the fixed three-stage fetch/decode/exec stall unit. It collects per-stage completion pulses, advances the whole pipeline in lock-step once every live stage has finished, and issues one-cycle per-stage enables. It tracks per-stage valid bits for fill and drain, and adds latched stall and flush requests, a halt/drain mode, and a saturating stall counter. It sits beside the core datapath and drives the enable input of every stage.

## Interface

Parameters:
- NSTAGE, 3: number of stages; stage 0 is fetch, stage NSTAGE-1 is the oldest (writeback side); NSTAGE >= 2.
- STALL_AT, NSTAGE-1: stage that receives a bubble on stall; 1 <= STALL_AT <= NSTAGE-1.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stage_done  in  NSTAGE  per-stage completion pulse for the stage's current op.
- stall_req  in  1  hazard request; re-issue stages below STALL_AT, bubble at STALL_AT.
- flush  in  1  redirect; kill all in-flight ops.
- halt  in  1  level; suppress new fetches so the pipeline drains.
- stage_enable  out  NSTAGE  one-cycle start pulse per stage.
- stage_valid  out  NSTAGE  registered: stage holds a live op.
- advance  out  1  high in the cycle the pipeline steps.
- idle  out  1  no valid stage and no pending work.
- stall_cnt  out  CNT_W  saturating count of stall advances.

## Operation

- State: valid[NSTAGE], done_acc[NSTAGE], stall_pend, flush_pend, stall_cnt.
- all_done = &(done_acc | stage_done). advance = all_done & ~rst.
- Effective requests: s = stall_req | stall_pend, f = flush | flush_pend.
- next_valid is computed in priority order:
  - If f: next_valid[0] = ~halt; every other bit is 0.
  - Else if s: next_valid[i] = valid[i] for i < STALL_AT (re-issue); next_valid[STALL_AT] = 0; next_valid[i] = valid[i-1] for i > STALL_AT.
  - Otherwise: next_valid[0] = ~halt; next_valid[i] = valid[i-1].
- On an advance cycle:
  - stage_enable = next_valid, combinationally in the same cycle.
  - valid <= next_valid; done_acc <= ~next_valid.
  - stall_pend and flush_pend are cleared.
  - If s & ~f, stall_cnt increments, saturating at all-ones.
- On a non-advance cycle:
  - stage_enable = 0.
  - done_acc <= done_acc | stage_done.
  - stall_pend |= stall_req; flush_pend |= flush.
- stage_done on a stage with done_acc already 1 is ignored.
- idle = ~|valid & all_done & ~halt_pending_work, where halt_pending_work = 0. In effect, idle = ~|valid & all_done.
- Reset values: valid = 0, done_acc = all ones, pending flags 0, stall_cnt = 0. Outputs during rst: stage_enable = 0, advance = 0, stage_valid = 0, stall_cnt = 0.

## Timing

- The first cycle after rst deasserts advances: stage_enable = 0…01 (fetch only), unless halt is high.
- A stage may assert stage_done no earlier than the cycle after its enable. A stage_done in its enable cycle belongs to the previous op.
- With every stage done one cycle after its enable, the pipeline advances every cycle: throughput is one op per cycle.
- Fill: stage k is first enabled on the (k+1)-th advance.
- Drain under halt: valid empties from stage 0 upward, one stage per advance. idle rises once valid = 0.
- stall_req/flush sampled on an advance cycle act immediately. Sampled earlier, they are held pending until the next advance. Each request is applied once per advance.
- Simultaneous stall and flush: flush wins, and the stall is dropped, not counted.
- A mid-operation rst discards pending requests and accumulated done bits. The next advance restarts from fetch.
- stall_cnt saturates and never wraps.

## Structure

- Shared package: stage index constants (STG_FETCH = 0), the next_valid priority encoding, and the CNT_W default.
- One natural sub-module, pipe_done_acc: per-stage done accumulation with the all_done reduction, instantiated once at width NSTAGE.
- The rest stays in pipe_ctrl: next_valid mux, pending flags, counter.

## Test plan

- NSTAGE = 3, every stage done one cycle after its enable: after reset, stage_enable = 001, 011, 111, then 111 every cycle; advance is high continuously.
- NSTAGE = 4, stage 2 done three cycles late: no advance until it is done; enables in the waiting cycles = 0; earlier done pulses stay accumulated.
- NSTAGE = 3, STALL_AT = 2, stall_req on a full pipe: next enable = 011, stage_valid = 011, stall_cnt = 1.
- flush raised together with stall_req while stage 1 is still busy: at the next advance, enable = 001, stall_cnt unchanged, flush_pend cleared.
- halt held on a full 4-stage pipe: valid goes 1110, 1100, 1000, 0000 over successive advances; idle = 1 afterwards; rst mid-drain gives enable = 0001 right after it is released, once halt is dropped.
- CNT_W = 2, five stall advances: stall_cnt = 3, holding at 3.
